gray_code_counter: RTL and testbench
====================================

Name: gray_code_counter

Overview:
- Sequential binary-to-Gray block: an up/down binary counter with a registered Gray-coded output.
- Produces the Gray sequences that the team's Gray-to-binary decoder consumes, for example as pointers across clock domains or as encoder-side stimulus.
- Gray and binary outputs are always mutually consistent; exactly one Gray bit changes per count step.

Parameters:
- WIDTH, 4, counter and code width in bits (minimum 2).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1.
- load  input  1  synchronous load of d; overrides en.
- d  input  WIDTH  load value; binary by default, Gray when GRAY_LOAD_EN is defined.
- b  output  WIDTH  registered binary count.
- g  output  WIDTH  registered Gray code of b, i.e. b ^ (b >> 1).
- wrap  output  1  one-cycle pulse flagging a count wrap-around.

Behaviour:
- Reset: asynchronous, active-high. While rst=1: b=0, g=0, wrap=0 immediately, independent of clk. First update occurs on the first rising edge after rst falls.
- Priority each edge: rst > load > en > hold.
- Load (load=1):
  - b <= loaded binary value; g <= Gray encoding of that value; wrap <= 0.
  - en and up are ignored.
- Count (load=0, en=1):
  - up=1: b <= b+1, modulo 2^WIDTH.
  - up=0: b <= b-1, modulo 2^WIDTH.
  - g <= Gray encoding of the next b. Both registers update on the same edge, so g carries no extra latency relative to b.
- Hold (load=0, en=0): b and g unchanged; wrap <= 0.
- wrap:
  - Set to 1 for exactly one cycle after an edge where up=1 and b goes from all-ones to 0.
  - Set to 1 for exactly one cycle after an edge where up=0 and b goes from 0 to all-ones.
  - 0 on every other edge.
- Invariants:
  - g == b ^ (b >> 1) at all times.
  - Across consecutive count steps, g has Hamming distance exactly 1, including at wrap-around.
  - Across a load, any Hamming distance is permitted.
- Direction change between cycles is legal; the Gray step is still single-bit.
- Arithmetic: unsigned WIDTH-bit; overflow and underflow wrap silently, with only the wrap pulse as indication.
- No X propagation from d when load=0.

Optional Feature:
- Macro: GRAY_LOAD_EN.
- Defined: d is a Gray code. It is decoded to binary, b(MSB)=d(MSB) and b(i)=b(i+1)^d(i), before loading. Consequently g <= d exactly on a load.
- Undefined: d is binary; g <= Gray encoding of d. No decoder logic is instantiated.

Decomposition:
- Shared package gray_pkg:
  - WIDTH default constant.
  - Function bin2gray(vector) -> vector.
  - Function gray2bin(vector) -> vector.
  - Direction constants DIR_UP=1, DIR_DOWN=0.
- Counter, wrap logic and output registers stay in gray_code_counter.
- One natural sub-module: gray_to_bin (combinational, WIDTH-parameterised), instantiated only under GRAY_LOAD_EN. It matches the existing decoder's g/b port naming so both can be checked against each other.

Test Plan (WIDTH=4):
- Reset then release, en=0 -> b=0000, g=0000, wrap=0 and held.
- en=1, up=1 for 16 cycles from 0 -> g sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000. wrap=1 only in the cycle after the 1000->0000 step. Hamming distance is 1 on every step.
- From b=0, en=1, up=0 -> b=1111, g=1000, wrap=1 for one cycle; next step gives b=1110, g=1001, wrap=0.
- load=1, en=1, d=1010 (binary build) -> load wins: b=1010, g=1111, wrap=0. With GRAY_LOAD_EN and d=1111 -> b=1010, g=1111.
- Count to b=0101, then assert rst asynchronously mid-cycle -> b=0000, g=0000, wrap=0 before the next edge. After release, counting resumes 0000->0001.
- Cross-check: feed g into the existing Gray-to-binary decoder on every cycle -> decoded value equals b across a 40-cycle random en/up/load sequence.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and constants for the Gray counter/decoder blocks.
package gray_pkg;
  localparam int WIDTH_DEF = 4;
  localparam int MAX_W     = 64;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Narrower callers zero-extend into MAX_W and take the low bits back.
  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] v);
    return v ^ (v >> 1);
  endfunction

  // Zero upper bits keep the prefix-XOR correct for any narrower width.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] v);
    logic [MAX_W-1:0] r;
    r[MAX_W-1] = v[MAX_W-1];
    for (int i = MAX_W-2; i >= 0; i--) r[i] = r[i+1] ^ v[i];
    return r;
  endfunction
endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary decoder; bit i is the XOR of all Gray bits at or above i.
module gray_to_bin
  import gray_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] b
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign b[i] = ^g[WIDTH-1:i];
  end
endmodule

// File: rtl/gray_code_counter.sv
// Up/down binary counter with registered Gray output and wrap pulse.
// Define GRAY_LOAD_EN to treat the load value d as Gray code instead of binary.
module gray_code_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] g,
  output logic             wrap
);
  logic [WIDTH-1:0] b_q, b_d, g_q, g_d, ld_bin;
  logic             wrap_q, wrap_d;
  logic [MAX_W-1:0] g_wide;

`ifdef GRAY_LOAD_EN
  gray_to_bin #(.WIDTH(WIDTH)) u_ld_dec (
    .g (d),
    .b (ld_bin)
  );
`else
  assign ld_bin = d;
`endif

  always_comb begin
    b_d    = b_q;
    wrap_d = 1'b0;
    if (load) begin
      b_d = ld_bin;
    end else if (en) begin
      if (up == DIR_UP) begin
        b_d    = b_q + 1'b1;
        wrap_d = &b_q;
      end else begin
        b_d    = b_q - 1'b1;
        wrap_d = ~|b_q;
      end
    end
  end

  // Encode the next binary value so g lands on the same edge as b.
  assign g_wide = bin2gray(MAX_W'(b_d));
  assign g_d    = g_wide[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_q    <= '0;
      g_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      b_q    <= b_d;
      g_q    <= g_d;
      wrap_q <= wrap_d;
    end
  end

  assign b    = b_q;
  assign g    = g_q;
  assign wrap = wrap_q;
endmodule

// File: tb/tb_gray_code_counter.sv
// Directed self-checking bench for gray_code_counter (WIDTH=4), cross-checked against gray_to_bin.
module tb_gray_code_counter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, en, up, load;
  logic [W-1:0] d, b, g, dec_b;
  logic         wrap;

  int checks = 0;
  int errors = 0;

  gray_code_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d),
    .b(b), .g(g), .wrap(wrap)
  );

  gray_to_bin #(.WIDTH(W)) u_ref (.g(g), .b(dec_b));

  always #5 clk = ~clk;

  function automatic logic [W-1:0] m_g2b(input logic [W-1:0] v);
    logic [W-1:0] r;
    r[W-1] = v[W-1];
    for (int i = W-2; i >= 0; i--) r[i] = r[i+1] ^ v[i];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; d = '0;
    #3;
    checks++;
    if (b !== 4'b0000 || g !== 4'b0000 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_async b=%b g=%b wrap=%b want 0000 0000 0", b, g, wrap);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (b !== 4'b0000 || g !== 4'b0000 || wrap !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold[%0d] b=%b g=%b wrap=%b want 0000 0000 0", i, b, g, wrap);
      end
    end
  endtask

  task automatic test_count_up();
    logic [W-1:0] seq [0:16];
    logic [W-1:0] prev;
    seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
            4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000,
            4'b0000};
    en = 1'b1; up = 1'b1;
    prev = g;
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if (g !== seq[i+1] || wrap !== (i == 15)) begin
        errors++;
        $display("FAIL count_up[%0d] g=%b wrap=%b want %b %b", i, g, wrap, seq[i+1], (i == 15));
      end
      checks++;
      if ($countones(prev ^ g) != 1) begin
        errors++;
        $display("FAIL up_hamming[%0d] prev=%b g=%b distance=%0d want 1", i, prev, g, $countones(prev ^ g));
      end
      prev = g;
    end
    step();
    checks++;
    if (b !== 4'b0001 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL wrap_one_cycle b=%b wrap=%b want 0001 0", b, wrap);
    end
  endtask

  task automatic test_count_down();
    en = 1'b0; load = 1'b1; d = '0;
    step();
    load = 1'b0; en = 1'b1; up = 1'b0;
    step();
    checks++;
    if (b !== 4'b1111 || g !== 4'b1000 || wrap !== 1'b1) begin
      errors++;
      $display("FAIL down_wrap b=%b g=%b wrap=%b want 1111 1000 1", b, g, wrap);
    end
    step();
    checks++;
    if (b !== 4'b1110 || g !== 4'b1001 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL down_step b=%b g=%b wrap=%b want 1110 1001 0", b, g, wrap);
    end
    up = 1'b1;
    step();
    checks++;
    if (b !== 4'b1111 || g !== 4'b1000 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL dir_change b=%b g=%b wrap=%b want 1111 1000 0", b, g, wrap);
    end
    en = 1'b0;
    step();
    checks++;
    if (b !== 4'b1111 || g !== 4'b1000 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL hold b=%b g=%b wrap=%b want 1111 1000 0", b, g, wrap);
    end
  endtask

  task automatic test_load();
    load = 1'b1; en = 1'b1; up = 1'b1;
`ifdef GRAY_LOAD_EN
    d = 4'b1111;
`else
    d = 4'b1010;
`endif
    step();
    checks++;
    if (b !== 4'b1010 || g !== 4'b1111 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL load_wins b=%b g=%b wrap=%b want 1010 1111 0", b, g, wrap);
    end
`ifdef GRAY_LOAD_EN
    d = 4'b1000;
`else
    d = 4'b1111;
`endif
    step();
    checks++;
    if (b !== 4'b1111 || g !== 4'b1000) begin
      errors++;
      $display("FAIL load_ones b=%b g=%b want 1111 1000", b, g);
    end
    // load at all-ones with en/up asserted must not pulse wrap
    step();
    checks++;
    if (b !== 4'b1111 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL load_no_wrap b=%b wrap=%b want 1111 0", b, wrap);
    end
    load = 1'b0; d = 'x;
    step();
    checks++;
    if (b !== 4'b0000 || g !== 4'b0000 || wrap !== 1'b1) begin
      errors++;
      $display("FAIL after_load_wrap b=%b g=%b wrap=%b want 0000 0000 1", b, g, wrap);
    end
    d = '0;
  endtask

  task automatic test_async_reset();
    load = 1'b1; en = 1'b0; d = '0;
    step();
    load = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (b !== 4'b0101 || g !== 4'b0111) begin
      errors++;
      $display("FAIL pre_reset b=%b g=%b want 0101 0111", b, g);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (b !== 4'b0000 || g !== 4'b0000 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL midcycle_reset b=%b g=%b wrap=%b want 0000 0000 0", b, g, wrap);
    end
    #2 rst = 1'b0;
    step();
    checks++;
    if (b !== 4'b0001 || g !== 4'b0001) begin
      errors++;
      $display("FAIL resume b=%b g=%b want 0001 0001", b, g);
    end
  endtask

  task automatic test_crosscheck();
    logic [W-1:0] mb, prev;
    logic         was_load;
    mb = b;
    for (int i = 0; i < 40; i++) begin
      en   = 1'($urandom_range(0, 1));
      up   = 1'($urandom_range(0, 1));
      load = ($urandom_range(0, 7) == 0);
      d    = W'($urandom_range(0, 15));
      was_load = load;
      prev = g;
      if (load) begin
`ifdef GRAY_LOAD_EN
        mb = m_g2b(d);
`else
        mb = d;
`endif
      end else if (en) begin
        mb = up ? mb + 1'b1 : mb - 1'b1;
      end
      step();
      checks++;
      if (b !== mb || g !== (mb ^ (mb >> 1)) || dec_b !== b) begin
        errors++;
        $display("FAIL xcheck[%0d] b=%b g=%b dec=%b want b=%b g=%b", i, b, g, dec_b, mb, mb ^ (mb >> 1));
      end
      if (!was_load && en) begin
        checks++;
        if ($countones(prev ^ g) != 1) begin
          errors++;
          $display("FAIL xcheck_hamming[%0d] prev=%b g=%b want distance 1", i, prev, g);
        end
      end
    end
    load = 1'b0; en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_async_reset();
    test_crosscheck();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
